// File: rtl/mem_port_arbiter_pkg.sv
// Shared core-wide definitions for the unified-memory port arbiter:
// default bus widths, response-owner encoding and the grant selector type.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    // Owner of an in-flight read response
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Which port (if any) owns the memory this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the rv32i core: instruction fetch and
// load/store share one synchronous memory. Data wins over fetch, but only
// for MAX_D_RUN consecutive grants while a fetch is waiting. Read data
// comes back one cycle after grant with a valid pulse to the owning port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The run counter never needs to exceed 15
    localparam logic [3:0] MAX_CNT = 4'(MAX_D_RUN);

    gnt_sel_e   gnt_sel;
    logic [3:0] d_run_cnt_d, d_run_cnt_q;
    logic       resp_valid_d, resp_valid_q;
    logic       resp_owner_d, resp_owner_q;

    // Arbitration: data first unless its run has starved a waiting fetch
    always_comb begin
        gnt_sel = GNT_NONE;
        if (d_req && (!if_req || (d_run_cnt_q < MAX_CNT))) begin
            gnt_sel = GNT_D;
        end else if (if_req) begin
            gnt_sel = GNT_IF;
        end else begin
            gnt_sel = GNT_NONE;
        end
    end

    // Memory drive and grant strobes from the selected port
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt_sel)
            GNT_IF: begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            GNT_D: begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                if_gnt = 1'b0;
                d_gnt  = 1'b0;
            end
        endcase
    end

    // Next-state for the starvation counter and response tracker
    always_comb begin
        d_run_cnt_d  = d_run_cnt_q;
        resp_valid_d = 1'b0;
        resp_owner_d = resp_owner_q;

        // Counter only measures data runs that actually block a fetch
        if (!if_req || (gnt_sel == GNT_IF)) begin
            d_run_cnt_d = 4'd0;
        end else if ((gnt_sel == GNT_D) && (d_run_cnt_q < MAX_CNT)) begin
            d_run_cnt_d = d_run_cnt_q + 4'd1;
        end else begin
            d_run_cnt_d = d_run_cnt_q;
        end

        // Stores grant the memory but produce no response
        if (gnt_sel == GNT_IF) begin
            resp_valid_d = 1'b1;
            resp_owner_d = OWN_IF;
        end else if (gnt_sel == GNT_D) begin
            resp_valid_d = ~d_we;
            resp_owner_d = OWN_D;
        end else begin
            resp_valid_d = 1'b0;
            resp_owner_d = resp_owner_q;
        end
    end

    // State registers; reset discards any response still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_run_cnt_q  <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWN_IF;
        end else begin
            d_run_cnt_q  <= d_run_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Read data is shared; the per-port valid decides who consumes it
    assign if_rvalid = resp_valid_q & (resp_owner_q == OWN_IF);
    assign d_rvalid  = resp_valid_q & (resp_owner_q == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch port and the load/store data port of the rv32i core.
- Sits between the datapath (pc fetch, aluRes/writeData access) and a unified memory, replacing the dual-port memory arrangement.
- Grants at most one access per cycle with data-over-fetch priority and a bounded anti-starvation rule.
- Returns read data one cycle after grant, with a valid pulse routed to the owning requester.

Parameters:
- ADDR_W, 16, byte address width on all ports.
- DATA_W, 32, data word width.
- MAX_D_RUN, 4, maximum consecutive data grants while a fetch is pending before fetch is forced (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address (pc).
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (registered pulse).
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered pulse).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, rst=1): d_run_cnt=0; resp_valid=0; resp_owner=IF; if_rvalid=d_rvalid=0.
  - Grants are combinational from req, so if_gnt=d_gnt=mem_en=0 while no req is asserted.
  - rst asserted mid-access discards any in-flight response: no rvalid pulse after reset.
- Arbitration (combinational, each cycle):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both, and d_run_cnt < MAX_D_RUN: grant data.
  - Both, and d_run_cnt == MAX_D_RUN: grant fetch.
  - Neither: mem_en=0, mem_we=0; mem_addr/mem_wdata hold don't-care (drive 0).
- Memory drive on grant: mem_en=1.
  - mem_we = d_we on data grant, 0 on fetch grant.
  - mem_addr/mem_wdata taken from the granted port.
- d_run_cnt register:
  - Increments (saturating at MAX_D_RUN) on a data grant while if_req=1.
  - Clears on any fetch grant, or in any cycle with if_req=0.
- Response tracking (registered):
  - resp_valid <= grant of a read (fetch, or data with d_we=0).
  - resp_owner <= granted port.
  - Stores produce no response.
- Read latency exactly 1 cycle:
  - if_rvalid = resp_valid & owner==IF; d_rvalid = resp_valid & owner==D.
  - if_rdata = d_rdata = mem_rdata (unmuxed; qualified by rvalid).
- Fully pipelined: a new grant may occur in the same cycle an rvalid is returned; back-to-back reads give one rvalid per cycle.
- Requester contract: req must stay high with stable payload until gnt. Dropping req before gnt withdraws the request, with no side effects.
- Simultaneous request with rst deasserting: the first grant is in the first cycle after rst falls, decided by the rules above.

Decomposition:
- Shared package (core-wide): ADDR_W/DATA_W defaults and the owner encoding constants OWN_IF=1'b0, OWN_D=1'b1.
- No sub-module: arbitration, counter and response register fit in a single module.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0004, mem holds 0x00500093 -> if_gnt same cycle, mem_addr=0x0004, mem_we=0; if_rvalid=1 and if_rdata=0x00500093 next cycle; d_rvalid stays 0.
- Contention: if_req=1 and d_req=1 (load, 0x0100) continuously, MAX_D_RUN=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF; rvalid pulses match owners one cycle later.
- Store: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0xDEADBEEF -> d_gnt, mem_we=1 same cycle; no rvalid; a following load from 0x0200 returns 0xDEADBEEF.
- Back-to-back alternating reads (IF at 0x0, D load at 0x10, IF at 0x4) -> rvalid every cycle after the first, owners IF,D,IF, data matching memory contents.
- Reset mid-read: grant a load, assert rst asynchronously before the next edge -> no d_rvalid afterwards; all outputs 0 while rst=1 and no req.
- Idle: no requests -> mem_en=0, mem_we=0, counters stay 0 over 10 cycles.
